// File: rtl/fifo_frame_packer_pkg.sv
// Shared types and constants for the sample-FIFO-to-UART frame packer.
package fifo_frame_packer_pkg;

    localparam int         WORD_W            = 24;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_LEN,
        ST_FETCH,
        ST_WAIT,
        ST_B2,
        ST_B1,
        ST_B0,
        ST_CSUM
    } state_t;

    // Total bytes on the wire for a frame of n words: sync, seq, len, payload, csum.
    function automatic int frame_len(input int n);
        return 4 + 3 * n;
    endfunction

endpackage

// File: rtl/fifo_frame_packer.sv
// Drains 24-bit ADC words from the sample FIFO and emits framed bytes
// (sync, seq, len, payload MSB-first, checksum) on a valid/ready byte stream.
module fifo_frame_packer
    import fifo_frame_packer_pkg::*;
#(
    parameter int         WORDS_PER_FRAME = 4,
    parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [7:0]        frame_seq
);

    localparam int         LEN_INT  = frame_len(WORDS_PER_FRAME) - 4;
    localparam logic [7:0] LEN_BYTE = LEN_INT[7:0];
    localparam logic [6:0] WPF      = WORDS_PER_FRAME[6:0];

    state_t              state_q, state_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [6:0]          word_cnt_q, word_cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          seq_q, seq_d;
    logic                accept;
    logic [7:0]          csum_sum;

    assign accept   = tx_valid_q && tx_ready;
    assign csum_sum = csum_q + tx_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            word_q     <= '0;
            word_cnt_q <= '0;
            csum_q     <= 8'h00;
            seq_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
        end
    end

    // Each state loads the byte for the following state, so tx_data/tx_valid stay registered.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        seq_d      = seq_q;
        fifo_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ST_SYNC;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                end
            end
            ST_SYNC: begin
                if (accept) begin
                    state_d   = ST_SEQ;
                    tx_data_d = seq_q;
                end
            end
            ST_SEQ: begin
                if (accept) begin
                    state_d   = ST_LEN;
                    tx_data_d = LEN_BYTE;
                    csum_d    = csum_sum;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    state_d    = ST_FETCH;
                    tx_valid_d = 1'b0;
                    csum_d     = csum_sum;
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                word_d     = fifo_data;
                tx_data_d  = fifo_data[23:16];
                tx_valid_d = 1'b1;
                state_d    = ST_B2;
            end
            ST_B2: begin
                if (accept) begin
                    state_d   = ST_B1;
                    tx_data_d = word_q[15:8];
                    csum_d    = csum_sum;
                end
            end
            ST_B1: begin
                if (accept) begin
                    state_d   = ST_B0;
                    tx_data_d = word_q[7:0];
                    csum_d    = csum_sum;
                end
            end
            ST_B0: begin
                if (accept) begin
                    csum_d     = csum_sum;
                    word_cnt_d = word_cnt_q + 7'd1;
                    if (word_cnt_q + 7'd1 == WPF) begin
                        // Checksum byte must include the B0 byte being accepted now.
                        state_d   = ST_CSUM;
                        tx_data_d = csum_sum;
                    end else begin
                        state_d    = ST_FETCH;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    seq_d      = seq_q + 8'd1;
                    word_cnt_d = '0;
                    csum_d     = 8'h00;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign frame_seq = seq_q;

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Scoreboard bench for fifo_frame_packer: stimulus queues expected bytes, a monitor checks them.
module tb_fifo_frame_packer;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [23:0] fifo_data;
    logic        fifo_rd_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  frame_seq;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_q[$];
    logic [23:0] mem[4096];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    fifo_frame_packer #(
        .WORDS_PER_FRAME(4),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .frame_seq (frame_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous FIFO model: read data appears one cycle after the strobe.
    assign fifo_empty = (wr_ptr == rd_ptr);
    initial fifo_data = 24'h0;
    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_data <= mem[rd_ptr % 4096];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected byte per transfer, checks hold stability and read strobes.
    initial begin
        logic       prev_pending;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_pending = 1'b0;
        prev_data    = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pending = 1'b0;
            end else begin
                if (prev_pending) begin
                    check("hold_valid", {31'd0, tx_valid}, 32'd1);
                    check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
                end
                if (fifo_rd_en)
                    check("rd_en_when_empty", {31'd0, fifo_empty}, 32'd0);
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (tx_data !== e) begin
                            errors++;
                            $display("FAIL byte: got %02h expected %02h", tx_data, e);
                        end else begin
                            $display("byte %02h ok (seq reg %02h)", tx_data, frame_seq);
                        end
                    end
                end
                prev_pending = tx_valid && !tx_ready;
                prev_data    = tx_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [23:0] w);
        mem[wr_ptr % 4096] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_frame(input logic [7:0] seq, input logic [23:0] w0, input logic [23:0] w1,
                                input logic [23:0] w2, input logic [23:0] w3);
        logic [23:0] w[4];
        logic [7:0]  sum;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        exp_q.push_back(8'h0C);
        sum = seq + 8'h0C;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(w[i][23:16]);
            exp_q.push_back(w[i][15:8]);
            exp_q.push_back(w[i][7:0]);
            sum = sum + w[i][23:16] + w[i][15:8] + w[i][7:0];
        end
        exp_q.push_back(sum);
    endtask

    task automatic wait_frame_done(input int max_cycles, input bit rnd, output int busy_cycles);
        bit done;
        done        = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            tick();
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (busy) busy_cycles++;
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check("frame_done_in_time", {31'd0, done}, 32'd1);
        tx_ready = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [7:0] golden[16];
        int         bc;
        golden = '{8'hA5, 8'h00, 8'h0C, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD,
                   8'hEF, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h0D};
        rst      = 1'b1;
        tx_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'h00);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_frame_seq", {24'd0, frame_seq}, 32'h00);
        check("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);

        // Empty FIFO: nothing must happen.
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("idle_quiet", {29'd0, tx_valid, fifo_rd_en, busy}, 32'd0);
        end

        // Frame 0: hand-computed golden stream, continuous ready.
        for (int i = 0; i < 16; i++) exp_q.push_back(golden[i]);
        tick();
        push_word(24'h123456); push_word(24'hABCDEF);
        push_word(24'h000001); push_word(24'hFFFFFF);
        wait_frame_done(100, 1'b0, bc);
        check("frame0_busy_cycles", bc, 32'd24);
        check("frame0_seq_after", {24'd0, frame_seq}, 32'h01);

        // Frame 1: same words under random backpressure.
        expect_frame(8'h01, 24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF);
        tick();
        push_word(24'h123456); push_word(24'hABCDEF);
        push_word(24'h000001); push_word(24'hFFFFFF);
        wait_frame_done(300, 1'b1, bc);
        check("frame1_seq_after", {24'd0, frame_seq}, 32'h02);

        // Frame 2: FIFO runs dry after two words, then refills.
        expect_frame(8'h02, 24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C);
        tick();
        push_word(24'h010203); push_word(24'h040506);
        repeat (40) tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_outputs", {29'd0, tx_valid, fifo_rd_en, busy}, 32'd1);
        end
        check("stall_bytes_left", exp_q.size(), 32'd7);
        tick();
        push_word(24'h070809); push_word(24'h0A0B0C);
        wait_frame_done(100, 1'b0, bc);
        check("frame2_seq_after", {24'd0, frame_seq}, 32'h03);

        // Reset while B1 is pending: only sync, seq, len and B2 go out.
        tx_ready = 1'b0;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h03);
        exp_q.push_back(8'h0C); exp_q.push_back(8'hC0);
        tick();
        push_word(24'hC0FFEE);
        for (int k = 0; k < 4; k++) begin
            wait_valid("rst_test_valid");
            tick(); tx_ready = 1'b1;
            tick(); tx_ready = 1'b0;
        end
        wait_valid("b1_pending_valid");
        check("b1_pending_data", {24'd0, tx_data}, 32'hFF);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_frame_seq", {24'd0, frame_seq}, 32'h00);
        check("midrst_bytes_left", exp_q.size(), 32'd0);

        // 257 back-to-back frames: seq 00..FF then 00 again.
        tx_ready = 1'b1;
        tick();
        for (int f = 0; f < 257; f++) begin
            logic [7:0] fb;
            fb = 8'(f);
            expect_frame(fb, {fb, 8'h11, ~fb}, {8'h80, fb, 8'h7F},
                         {~fb, fb, fb}, {8'h00, 8'h5A, fb});
            push_word({fb, 8'h11, ~fb}); push_word({8'h80, fb, 8'h7F});
            push_word({~fb, fb, fb});    push_word({8'h00, 8'h5A, fb});
        end
        wait_frame_done(257 * 30 + 100, 1'b0, bc);
        check("seq_after_wrap", {24'd0, frame_seq}, 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_frame_packer.md
# fifo_frame_packer

Downstream stage of the acquisition controller. Drains 24-bit ADC result words from the synchronous sample FIFO and packs them into fixed-length byte frames: sync byte, sequence number, length, payload, checksum. Frames are presented on a byte-wide valid/ready stream that feeds the host UART transmitter.

## Interface
Parameters:
- WORDS_PER_FRAME, 4: 24-bit words per frame; legal range 1..85, so LEN = 3*N fits in 8 bits.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  sample FIFO empty flag.
- fifo_data  in  24  FIFO read data; valid exactly 1 cycle after a cycle with fifo_rd_en=1.
- fifo_rd_en  out  1  single-cycle FIFO read strobe.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- busy  out  1  high from leaving IDLE until the checksum byte is accepted.
- frame_seq  out  8  sequence number of the next frame to be sent.

## Operation
- Frame byte order: SYNC_BYTE, SEQ, LEN(=3*WORDS_PER_FRAME), then each word MSB-first ([23:16], [15:8], [7:0]), then CSUM.
- CSUM is the 8-bit sum mod 256 of SEQ, LEN and all payload bytes. SYNC_BYTE is excluded.
- Byte transfer happens on a cycle with tx_valid && tx_ready. While tx_valid=1, tx_data is held stable until it is accepted. tx_valid is never withdrawn without acceptance, except by rst.
- States:
  - IDLE: busy=0. If !fifo_empty, go to SYNC.
  - SYNC, SEQ, LEN: present the byte; advance on accept.
  - FETCH: if !fifo_empty, pulse fifo_rd_en and go to WAIT. Otherwise stay; no timeout.
  - WAIT: capture fifo_data into the word register; go to B2.
  - B2, B1, B0: present the word bytes. After B0 is accepted, word_cnt+1. If word_cnt reaches WORDS_PER_FRAME go to CSUM, else go to FETCH.
  - CSUM: present the checksum. On accept, frame_seq+1 (wraps 255→0), clear word_cnt and the checksum accumulator, go to IDLE.
- The checksum accumulator adds each byte at its accept cycle, for SEQ, LEN and payload bytes.
- The FIFO is read only in FETCH, one word per frame slot. Words are never dropped or read ahead.
- rst mid-frame: the frame is abandoned. The current byte is not completed, and the next frame starts from SYNC with SEQ=0.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, fifo_rd_en=0, busy=0, frame_seq=0; internal counters and accumulator 0.
- Registered outputs only; no combinational path from tx_ready to tx_valid or tx_data.
- IDLE with fifo_empty=0 at cycle t gives tx_valid=1, tx_data=SYNC_BYTE at t+1.
- Byte accepted at cycle t gives the next byte valid at t+1, so with tx_ready held high there is one byte per cycle. The exception is at word boundaries.
- Word boundary: B0 accepted at t → FETCH at t+1 (fifo_rd_en=1 if non-empty) → WAIT at t+2 (capture) → B2 valid at t+3. That is a 2-cycle bubble per word.
- Frame length is 4+3N bytes. With N=4, continuous tx_ready and a non-empty FIFO, the frame takes 16 byte cycles plus 4×2 bubbles plus 1 IDLE cycle.
- fifo_rd_en is never high when fifo_empty=1 in the same cycle.

## Structure
- Shared package: state enum, SYNC_BYTE default, a WORD_W=24 constant, and a frame_len(N) function.
- Single module, no sub-module. The byte mux, checksum adder and word counter are inline.

## Test plan
- N=4, tx_ready=1, FIFO preloaded with 123456, ABCDEF, 000001, FFFFFF → stream A5 00 0C 12 34 56 AB CD EF 00 00 01 FF FF FF 0D; frame_seq 0→1; busy falls after 0D is accepted.
- tx_ready toggled with a random pattern during the same frame → identical byte sequence; tx_data stable whenever tx_valid && !tx_ready; no duplicate or skipped bytes.
- FIFO empties after 2 words → FSM holds in FETCH with tx_valid=0 and fifo_rd_en=0. A push of the third word resumes the frame, and the frame completes correctly.
- 256 back-to-back frames → SEQ bytes 00..FF, then 00; CSUM correct for every frame (scoreboard model).
- rst asserted while B1 is pending → next cycle tx_valid=0, busy=0, frame_seq=0; the next frame starts with A5 00.
- FIFO empty and tx_ready=1 held for 100 cycles after reset → tx_valid stays 0, fifo_rd_en stays 0, busy stays 0.
